sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_resp_pkg.sv | 29 ++
 rtl/sram_resp_fifo.sv | 95 +++++++++
 rtl/sram_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM responder.
// The package holds:
//   - the transfer size encodings (informational only; wstrb selects the lanes),
//   - the default ADDR_W, LAT and QDEPTH values,
//   - the request-queue entry struct.
// The word index field is sized for a full 32-bit byte address, which is
// 30 bits. Each instance uses only its low ADDR_W bits, so aliasing is
// resolved at the memory, not in the queue.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LAT    = 2;
  localparam int DEF_QDEPTH = 2;
  localparam int WIDX_W     = 30;

  typedef struct packed {
    logic              wr;
    logic [3:0]        wstrb;
    logic [WIDX_W-1:0] widx;
    logic [31:0]       wdata;
  } req_entry_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order request queue with a latency counter on each entry.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   push         - enqueue push_entry this cycle (caller ensures not_full)
//   push_entry   - request fields to store
//   pop          - retire the head entry this cycle (caller uses head_ready)
//   not_full     - fewer than QDEPTH entries held (forced low during reset)
//   head_ready   - head entry exists and its latency counter has reached 0
//   head_entry   - fields of the oldest entry
// An entry is loaded with LAT-1 when it is pushed. Every counter then counts
// down to 0 and stays there. A young entry that reaches 0 simply waits until
// it becomes the head, which keeps completion strictly in order.
module sram_resp_fifo
  import sram_resp_pkg::*;
#(
  parameter int LAT    = DEF_LAT,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  req_entry_t push_entry,
  input  logic       pop,
  output logic       not_full,
  output logic       head_ready,
  output req_entry_t head_entry
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [3:0] LAT_INIT = 4'(LAT - 1);

  // Payload storage carries no reset; occupancy is tracked by count_q.
  req_entry_t ent_q [QDEPTH];

  logic [3:0]    lat_q [QDEPTH];
  logic [3:0]    lat_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_full   = !reset && (count_q < CW'(QDEPTH));
  assign head_ready = (count_q != '0) && (lat_q[rd_ptr_q] == 4'd0);
  assign head_entry = ent_q[rd_ptr_q];

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      lat_d[i] = (lat_q[i] != 4'd0) ? lat_q[i] - 4'd1 : 4'd0;
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // The slot at wr_ptr_q is free whenever push is legal, so the load
    // can never clobber a live counter.
    if (push) begin
      lat_d[wr_ptr_q] = LAT_INIT;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        lat_q[i] <= 4'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      lat_q    <= lat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Word-organised SRAM model behind an addr_ok/data_ok request interface.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   req, wr     - request valid; 1 = write, 0 = read
//   size        - transfer size (informational; wstrb selects the lanes)
//   wstrb       - byte-lane write enables
//   addr, wdata - byte address (word index = addr[ADDR_W+1:2]) and write data
//   addr_ok     - a request is accepted in any cycle where req & addr_ok
//   data_ok     - the oldest outstanding request completes this cycle
//   rdata       - read data; zero unless data_ok is high on a read
// Accepted requests wait LAT cycles in the queue and retire in order.
// A write changes memory only at its own completion edge. Because
// completion is in order, a later read in the same queue returns the
// merged word.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LAT    = DEF_LAT,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Memory contents survive reset.
  logic [31:0] mem_q [DEPTH];

  req_entry_t        push_entry;
  req_entry_t        head_entry;
  logic              push;
  logic              not_full;
  logic              head_ready;
  logic [ADDR_W-1:0] head_idx;
  logic [31:0]       head_word;
  logic [31:0]       merged_d;
  logic              unused_bits;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  assign addr_ok = not_full;
  assign push    = req && not_full;

  assign push_entry.wr    = wr;
  assign push_entry.wstrb = wstrb;
  assign push_entry.widx  = addr[31:2];
  assign push_entry.wdata = wdata;

  sram_resp_fifo #(
    .LAT    (LAT),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (head_ready),
    .not_full   (not_full),
    .head_ready (head_ready),
    .head_entry (head_entry)
  );

  // Dropping the upper index bits here is what makes addresses alias.
  assign head_idx  = head_entry.widx[ADDR_W-1:0];
  assign head_word = mem_q[head_idx];
  assign data_ok   = head_ready && !reset;

  always_comb begin
    merged_d = lane_merge(head_word, head_entry.wdata, head_entry.wstrb);
    rdata    = '0;
    if (data_ok && !head_entry.wr) begin
      rdata = head_word;
    end
  end

  always_ff @(posedge clk) begin
    if (data_ok && head_entry.wr) begin
      mem_q[head_idx] <= merged_d;
    end
  end

  assign unused_bits = ^{size, addr[1:0], head_entry.widx[WIDX_W-1:ADDR_W]};

endmodule
